// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: single-cycle hits, whole-line
// refill in ascending word order over a word-wide memory bus, sticky flush.
module icache_dm #(
  parameter int unsigned NUM_LINES  = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        ready,
  output logic        valid,
  output logic [31:0] data,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);

  localparam int unsigned WB = $clog2(LINE_WORDS);
  localparam int unsigned IB = $clog2(NUM_LINES);
  localparam int unsigned TW = 30 - WB - IB;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_FLUSH} state_t;

  state_t                 r_state, w_next;
  logic [NUM_LINES-1:0]   r_vbits;
  logic [TW-1:0]          r_tags  [NUM_LINES];
  logic [31:0]            r_words [NUM_LINES][LINE_WORDS];
  logic [TW-1:0]          r_tag_l;
  logic [IB-1:0]          r_idx_l;
  logic [WB-1:0]          r_off_l;
  logic [WB-1:0]          r_cnt;
  logic                   r_pend;
  logic                   r_valid;
  logic [31:0]            r_data;
  logic [31:0]            r_word;

  logic [TW-1:0]          w_tag;
  logic [IB-1:0]          w_idx;
  logic [WB-1:0]          w_off;
  logic                   w_hit, w_accept, w_ack, w_last;

  assign w_off    = addr[WB+1:2];
  assign w_idx    = addr[WB+IB+1:WB+2];
  assign w_tag    = addr[31:WB+IB+2];
  assign w_hit    = r_vbits[w_idx] && (r_tags[w_idx] == w_tag);
  assign w_accept = req && ready;
  assign w_ack    = (r_state == S_REFILL) && mem_ack;
  assign w_last   = w_ack && (r_cnt == WB'(LINE_WORDS - 1));

  assign valid = r_valid;
  assign data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (flush || r_pend)        w_next = S_FLUSH;
        else if (w_accept && !w_hit) w_next = S_REFILL;
      end
      S_REFILL: if (w_last) w_next = S_IDLE;
      S_FLUSH:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready    = !rst && (r_state == S_IDLE) && !r_pend && !flush;
    mem_req  = (r_state == S_REFILL);
    mem_addr = '0;
    if (r_state == S_REFILL) mem_addr = {r_tag_l, r_idx_l, r_cnt, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vbits <= '0;
      r_tag_l <= '0;
      r_idx_l <= '0;
      r_off_l <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_word  <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_hit) begin
              r_valid <= 1'b1;
              r_data  <= r_words[w_idx][w_off];
            end else begin
              r_tag_l <= w_tag;
              r_idx_l <= w_idx;
              r_off_l <= w_off;
              r_cnt   <= '0;
            end
          end
        end
        S_REFILL: begin
          if (flush) r_pend <= 1'b1;
          if (w_ack) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == r_off_l) r_word <= mem_data;
            // The requested word may be the one arriving on the final ack.
            if (w_last) begin
              r_vbits[r_idx_l] <= 1'b1;
              r_valid          <= 1'b1;
              r_data           <= (r_cnt == r_off_l) ? mem_data : r_word;
            end
          end
        end
        S_FLUSH: begin
          r_vbits <= '0;
          r_pend  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Line storage needs no reset; a line's valid bit gates every read.
  always_ff @(posedge clk) begin
    if (!rst && w_ack)  r_words[r_idx_l][r_cnt] <= mem_data;
    if (!rst && w_last) r_tags[r_idx_l]         <= r_tag_l;
  end

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios then random fetches, checked against
// a line-level model of cache contents (valid/tag/words per index).
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        flush = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic        ready, valid, mem_req;
  logic [31:0] data, mem_addr;

  int nchk = 0;
  int nerr = 0;

  logic        mv [64];
  logic [21:0] mt [64];
  logic [31:0] mw [64][4];
  logic [31:0] dq [$];
  logic [31:0] last_data = '0;

  icache_dm #(.NUM_LINES(64), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .ready(ready),
    .valid(valid), .data(data), .flush(flush), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model;
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
  endtask

  task automatic idle_cycle;
    tick;
    chk("idle_valid", {31'b0, valid}, 32'd0);
    chk("idle_data_hold", data, last_data);
  endtask

  task automatic fetch(input logic [31:0] a, input int stall_at, input int stall_n,
                       input bit flush_mid);
    logic [5:0]  idx;
    logic [21:0] tg;
    logic [1:0]  off;
    logic [31:0] base;
    logic [31:0] w [4];
    idx  = a[9:4];
    tg   = a[31:10];
    off  = a[3:2];
    base = {a[31:4], 4'h0};
    chk("ready_before_req", {31'b0, ready}, 32'd1);
    req  = 1'b1;
    addr = a;
    tick;
    req  = 1'b0;
    if (mv[idx] && mt[idx] == tg) begin
      chk("hit_valid", {31'b0, valid}, 32'd1);
      chk("hit_data", data, mw[idx][off]);
      chk("hit_no_mem_req", {31'b0, mem_req}, 32'd0);
      chk("hit_ready", {31'b0, ready}, 32'd1);
      last_data = mw[idx][off];
    end else begin
      chk("miss_ready_low", {31'b0, ready}, 32'd0);
      chk("miss_no_valid", {31'b0, valid}, 32'd0);
      for (int k = 0; k < 4; k++) begin
        if (k == stall_at) begin
          for (int s = 0; s < stall_n; s++) begin
            chk("stall_mem_req", {31'b0, mem_req}, 32'd1);
            chk("stall_mem_addr", mem_addr, base + 32'(4 * k));
            chk("stall_no_valid", {31'b0, valid}, 32'd0);
            tick;
          end
        end
        chk("refill_mem_req", {31'b0, mem_req}, 32'd1);
        chk("refill_mem_addr", mem_addr, base + 32'(4 * k));
        chk("refill_no_valid", {31'b0, valid}, 32'd0);
        if (dq.size() > 0) w[k] = dq.pop_front();
        else               w[k] = $urandom;
        mem_ack  = 1'b1;
        mem_data = w[k];
        if (flush_mid && k == 1) flush = 1'b1;
        tick;
        mem_ack = 1'b0;
        flush   = 1'b0;
      end
      chk("resp_valid", {31'b0, valid}, 32'd1);
      chk("resp_data", data, w[off]);
      chk("resp_mem_req_low", {31'b0, mem_req}, 32'd0);
      last_data = w[off];
      mv[idx] = 1'b1;
      mt[idx] = tg;
      for (int k = 0; k < 4; k++) mw[idx][k] = w[k];
      if (flush_mid) begin
        chk("pend_ready_low", {31'b0, ready}, 32'd0);
        tick;
        chk("flush_ready_low", {31'b0, ready}, 32'd0);
        chk("flush_no_valid", {31'b0, valid}, 32'd0);
        tick;
        clear_model;
      end
      chk("resp_ready", {31'b0, ready}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] ra;
    clear_model;

    rst = 1'b1;
    tick;
    tick;
    chk("rst_ready_low", {31'b0, ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready_high", {31'b0, ready}, 32'd1);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // Cold miss then a hit streak on the same line.
    dq.push_back(32'hA0); dq.push_back(32'hA1); dq.push_back(32'hA2); dq.push_back(32'hA3);
    fetch(32'h100, -1, 0, 1'b0);
    fetch(32'h108, -1, 0, 1'b0);
    fetch(32'h10C, -1, 0, 1'b0);
    fetch(32'h100, -1, 0, 1'b0);
    idle_cycle;

    // Conflict eviction, then the evicted line misses again with a bus stall.
    dq.push_back(32'hB0); dq.push_back(32'hB1); dq.push_back(32'hB2); dq.push_back(32'hB3);
    fetch(32'h500, -1, 0, 1'b0);
    fetch(32'h10C, 1, 3, 1'b0);
    idle_cycle;

    // Flush during refill, then the flushed line misses.
    fetch(32'h900, -1, 0, 1'b1);
    fetch(32'h100, -1, 0, 1'b0);

    // Flush in IDLE wins over a simultaneous request.
    flush = 1'b1;
    req   = 1'b1;
    addr  = 32'h100;
    #1;
    chk("flush_idle_ready_low", {31'b0, ready}, 32'd0);
    tick;
    flush = 1'b0;
    req   = 1'b0;
    chk("flush_idle_no_valid", {31'b0, valid}, 32'd0);
    chk("flush_idle_state_ready", {31'b0, ready}, 32'd0);
    tick;
    chk("flush_idle_done_ready", {31'b0, ready}, 32'd1);
    chk("flush_idle_done_valid", {31'b0, valid}, 32'd0);
    clear_model;

    // Reset after two acks of a refill.
    req  = 1'b1;
    addr = 32'h100;
    tick;
    req = 1'b0;
    chk("rmid_miss_ready_low", {31'b0, ready}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      chk("rmid_mem_addr", mem_addr, 32'h100 + 32'(4 * k));
      mem_ack  = 1'b1;
      mem_data = 32'hC0 + 32'(k);
      tick;
      mem_ack = 1'b0;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    clear_model;
    last_data = '0;
    chk("rmid_mem_req_low", {31'b0, mem_req}, 32'd0);
    chk("rmid_no_valid", {31'b0, valid}, 32'd0);
    chk("rmid_data_cleared", data, 32'd0);
    chk("rmid_ready", {31'b0, ready}, 32'd1);
    mem_ack  = 1'b1;
    mem_data = 32'hDEAD;
    tick;
    mem_ack = 1'b0;
    chk("stray_ack_no_valid", {31'b0, valid}, 32'd0);
    chk("stray_ack_no_mem_req", {31'b0, mem_req}, 32'd0);
    fetch(32'h100, -1, 0, 1'b0);

    // Random fetches over a few tags and indices to mix hits and conflicts.
    for (int n = 0; n < 80; n++) begin
      ra = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
           (32'($urandom_range(0, 3)) << 2)  | 32'($urandom_range(0, 3));
      fetch(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
            ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) idle_cycle;
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the core's fetch stage and a word-wide backing memory bus.
- Fetch side: accepts one word-address request per cycle when ready; returns the instruction word with a one-cycle `valid` pulse.
- Misses refill a whole line from memory in ascending word order, then answer the pending fetch.
- `flush` invalidates every line.

Parameters:
NUM_LINES  64  number of cache lines; power of two, >= 2
LINE_WORDS  4  32-bit words per line; power of two, >= 2

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req  input  1  fetch request; accepted only when ready=1
addr  input  32  fetch byte address; addr[1:0] ignored
ready  output  1  cache can accept req this cycle
valid  output  1  one-cycle pulse: data holds the requested word
data  output  32  instruction word for the last accepted request
flush  input  1  invalidate all lines (sticky until performed)
mem_req  output  1  memory word read request, held until acked
mem_addr  output  32  word-aligned memory read address
mem_ack  input  1  memory returns mem_data this cycle
mem_data  input  32  memory read data, valid when mem_ack=1

Behaviour:
- Address split (WB = log2 LINE_WORDS, IB = log2 NUM_LINES):
  - word offset = addr[WB+1:2]
  - index = addr[WB+IB+1:WB+2]
  - tag = addr[31:WB+IB+2]
- Storage: per line one valid bit, one tag, and LINE_WORDS data words.
- Reset (synchronous, rst=1 at a rising edge):
  - all valid bits cleared; FSM to IDLE; refill counter 0; pending flush cleared.
  - outputs: valid=0, data=0, mem_req=0, mem_addr=0; ready=0 while rst=1, ready=1 the first cycle after rst deasserts.
- FSM states: IDLE, REFILL, FLUSH.
- IDLE:
  - ready=1 unless a flush is pending or flush=1.
  - flush has priority over req: go to FLUSH; req ignored that cycle.
- IDLE, req=1 and ready=1: combinational tag compare at the edge.
  - Hit: next cycle valid=1, data=word. Stay IDLE, so back-to-back hits give one word per cycle.
  - Miss: latch tag/index/offset; next state REFILL; ready=0 from the next cycle.
- REFILL:
  - mem_req=1, mem_addr={tag,index,cnt,2'b00}, cnt starts at 0.
  - mem_addr and mem_req stay stable until mem_ack=1.
  - On each mem_ack: write mem_data to line[index][cnt]; cnt++. If cnt==latched offset, also capture the word for the response.
  - On the ack with cnt==LINE_WORDS-1:
    - set valid bit and tag for the line.
    - next cycle: mem_req=0, valid=1, data=requested word, state IDLE, ready=1 (unless a flush is pending).
  - Miss latency = (cycle of last ack) + 1.
  - mem_ack while mem_req=0 is ignored in every state.
- flush during REFILL: refill completes normally, the response is still delivered, and flush is recorded pending.
- FLUSH (one cycle):
  - clear all valid bits; clear pending flag; ready=0.
  - next state IDLE.
- When the response pulse and a pending flush coincide, FLUSH follows, so ready stays low one extra cycle.
- valid is never asserted in the same cycle as ready=0 caused by a new miss.
- valid is 0 in every cycle not listed above.
- data holds its last value when valid=0.
- Reset mid-refill:
  - refill abandoned; line stays invalid; mem_req=0 the next cycle.
  - no valid pulse for the aborted request.
- Refilling a line overwrites its previous tag (conflict eviction); no other line is affected.

Test Plan (NUM_LINES=64, LINE_WORDS=4: tag=addr[31:10], index=addr[9:4]):
- Cold miss: after reset, req addr=0x100.
  - Expect ready=0 next cycle; mem_addr 0x100, 0x104, 0x108, 0x10C.
  - Ack each cycle with mem_data 0xA0, 0xA1, 0xA2, 0xA3.
  - Expect valid=1, data=0xA0 one cycle after the 4th ack; ready=1.
- Hit streak: req 0x108, then 0x10C, then 0x100 on consecutive cycles.
  - Expect valid=1 three consecutive cycles with data 0xA2, 0xA3, 0xA0; mem_req stays 0; ready stays 1.
- Conflict: req 0x500 (same index 0x10, new tag), refill with 0xB0..0xB3.
  - Expect data=0xB0.
  - Then req 0x100: expect a miss, mem_addr=0x100 issued.
- Bus stall: during refill, hold mem_ack=0 for 3 cycles between words 1 and 2.
  - Expect mem_addr=0x104 and mem_req=1 held stable; no valid until the final ack + 1.
  - With a req at offset 3 (0x10C), expect data = the 4th mem_data.
- Flush: pulse flush during REFILL.
  - Expect the response delivered, then one FLUSH cycle with ready=0.
  - Then req 0x100 misses (mem_req=1).
  - Flush in IDLE with req=1: req ignored; no valid pulse.
- Reset mid-refill: assert rst after 2 acks.
  - Expect mem_req=0 next cycle and no valid pulse.
  - A stray mem_ack is ignored.
  - req 0x100 afterwards misses and refills from 0x100.
